// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic block family.
// Contents:
//   arith_state_t - IDLE / CALC / DONE encoding for iterative arithmetic FSMs
//   cnt_width()   - width of an iteration counter that must hold the value w
package arith_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } arith_state_t;

    // Counter must represent the full iteration count w itself, hence w+1.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step (purely combinational).
// Ports:
//   rem      in  WIDTH  partial remainder entering the step (always < div)
//   a_msb    in  1      next dividend bit shifted into the remainder
//   div      in  WIDTH  divisor
//   rem_next out WIDTH  partial remainder after the step
//   q_bit    out 1      quotient bit produced by the step
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             a_msb,
    input  logic [WIDTH-1:0] div,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    // The shifted remainder can reach 2*div-1, so the trial is one bit wider
    // than the operands; this keeps all-ones divisors and dividends exact.
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    always_comb begin
        shifted  = {rem, a_msb};
        trial    = shifted - {1'b0, div};
        q_bit    = (shifted >= {1'b0, div});
        // Either branch is < div here, so the top bit is always zero.
        rem_next = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/div_unsigned.sv
// Iterative unsigned divider, one quotient bit per clock, MSB first.
// Ports:
//   clk   in   1      clock, rising edge
//   rst   in   1      synchronous active-high reset
//   start in   1      begin a division (ignored while busy)
//   a     in   WIDTH  dividend, captured on accepted start
//   b     in   WIDTH  divisor, captured on accepted start
//   busy  out  1      iteration in progress
//   done  out  1      one-cycle pulse; q, r, dbz valid
//   q     out  WIDTH  quotient (all ones on divide by zero)
//   r     out  WIDTH  remainder (dividend on divide by zero)
//   dbz   out  1      divide-by-zero flag for the presented result
module div_unsigned
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             dbz
);

    localparam int CW = cnt_width(WIDTH);

    arith_state_t     state_reg, state_next;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] quo_reg;   // dividend shifts out the top, quotient bits in the bottom
    logic [WIDTH-1:0] div_reg;
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] r_reg;
    logic             dbz_reg;

    logic             accept;
    logic             last_step;
    logic [WIDTH-1:0] rem_next;
    logic             q_bit;

    assign accept    = start && (state_reg != ST_CALC);
    assign last_step = (state_reg == ST_CALC) && (cnt_reg == CW'(1));

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_reg),
        .a_msb    (quo_reg[WIDTH-1]),
        .div      (div_reg),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; DONE accepts a new start so results can stream back to back.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_next = (b == '0) ? ST_DONE : ST_CALC;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (cnt_reg == CW'(1)) begin
                    state_next = ST_DONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy = (state_reg == ST_CALC);
        done = (state_reg == ST_DONE);
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
            quo_reg <= '0;
            div_reg <= '0;
            rem_reg <= '0;
            q_reg   <= '0;
            r_reg   <= '0;
            dbz_reg <= 1'b0;
        end else if (accept) begin
            quo_reg <= a;
            div_reg <= b;
            rem_reg <= '0;
            if (b == '0) begin
                // No iteration needed; result is presented directly.
                cnt_reg <= '0;
                q_reg   <= '1;
                r_reg   <= a;
                dbz_reg <= 1'b1;
            end else begin
                cnt_reg <= CW'(WIDTH);
            end
        end else if (state_reg == ST_CALC) begin
            rem_reg <= rem_next;
            quo_reg <= {quo_reg[WIDTH-2:0], q_bit};
            cnt_reg <= cnt_reg - CW'(1);
            if (last_step) begin
                q_reg   <= {quo_reg[WIDTH-2:0], q_bit};
                r_reg   <= rem_next;
                dbz_reg <= 1'b0;
            end
        end
    end

    assign q   = q_reg;
    assign r   = r_reg;
    assign dbz = dbz_reg;

endmodule

// File: tb/tb_div_unsigned.sv
// Self-checking bench for div_unsigned (WIDTH=8): directed corner cases
// followed by a randomized back-to-back stream against an arithmetic model.
module tb_div_unsigned;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;

    int total = 0;
    int bad   = 0;

    div_unsigned #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .q     (q),
        .r     (r),
        .dbz   (dbz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation (caller is 1 ns past an edge), wait for done,
    // check latency and result against plain arithmetic.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input string tag);
        int lat;
        int exp_q, exp_r, exp_lat;
        logic exp_dbz;
        if (bv == 0) begin
            exp_q = (1 << W) - 1; exp_r = av; exp_dbz = 1'b1; exp_lat = 1;
        end else begin
            exp_q = av / bv; exp_r = av % bv; exp_dbz = 1'b0; exp_lat = W + 1;
        end
        a = av; b = bv; start = 1'b1;
        tick();
        start = 1'b0;
        a = $urandom; b = $urandom;          // results must not depend on live inputs
        if (bv != 0) chk({tag, "_busy"}, busy, 1);
        lat = 1;
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_q"}, q, exp_q);
        chk({tag, "_r"}, r, exp_r);
        chk({tag, "_dbz"}, dbz, exp_dbz);
        if (bv != 0) begin
            chk({tag, "_mul"}, q * bv + r, av);
            chk({tag, "_rltb"}, (r < bv), 1);
        end
        $display("op %s a=%0d b=%0d -> q=%0d r=%0d dbz=%0d lat=%0d", tag, av, bv, q, r, dbz, lat);
    endtask

    initial begin
        int dones;
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_q", q, 0);
        chk("rst_r", r, 0);
        chk("rst_dbz", dbz, 0);

        // rst and start together: start dropped
        a = 8'd20; b = 8'd3; start = 1'b1;
        tick();
        start = 1'b0; rst = 1'b0;
        tick();
        chk("rststart_busy", busy, 0);
        chk("rststart_done", done, 0);

        // Directed results
        run_op(8'd200, 8'd7, "d200_7");
        tick();
        chk("hold_done", done, 0);
        chk("hold_q", q, 28);
        chk("hold_r", r, 4);
        run_op(8'd5, 8'd9, "d5_9");
        run_op(8'd255, 8'd1, "d255_1");
        run_op(8'd255, 8'd255, "d255_255");
        run_op(8'd0, 8'd1, "d0_1");
        run_op(8'd13, 8'd0, "d13_0");
        run_op(8'd10, 8'd3, "d10_3");
        tick();

        // Start during CALC is ignored
        a = 8'd100; b = 8'd3; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        a = 8'd50; b = 8'd5; start = 1'b1;
        tick();
        start = 1'b0;
        dones = 0;
        for (int i = 0; i < 25; i++) begin
            if (done) begin
                dones++;
                chk("ign_q", q, 33);
                chk("ign_r", r, 1);
            end
            tick();
        end
        chk("ign_dones", dones, 1);
        $display("op ignore_mid_calc dones=%0d", dones);

        // Reset during the 4th CALC cycle aborts the operation
        a = 8'd200; b = 8'd7; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_q", q, 0);
        chk("abort_r", r, 0);
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            if (done) dones++;
            tick();
        end
        chk("abort_nodone", dones, 0);
        $display("op reset_abort dones=%0d", dones);
        run_op(8'd77, 8'd6, "after_abort");

        // Randomized back-to-back stream: each start is issued in the DONE cycle
        for (int i = 0; i < 2500; i++) begin
            logic [W-1:0] av, bv;
            av = $urandom;
            bv = $urandom;
            case ($urandom_range(0, 15))
                0: bv = '0;
                1: bv = '1;
                2: av = '1;
                3: bv = 8'd1;
                default: ;
            endcase
            run_op(av, bv, $sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
